// File: rtl/wb_dma_sched_pkg.sv
// Shared types and constants for the DMA channel scheduler: FSM states,
// default sizing and the priority-level masks selected by pri_sel.
package wb_dma_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_GRANT = 2'd2,
        ST_BUSY  = 2'd3
    } sched_state_e;

    localparam int CH_NUM_DEF = 31;
    localparam int PRI_W_DEF  = 3;

    localparam logic [7:0] PRI_MASK_2L = 8'h01;
    localparam logic [7:0] PRI_MASK_4L = 8'h03;
    localparam logic [7:0] PRI_MASK_8L = 8'hFF;

    function automatic logic [7:0] pri_mask(input logic [1:0] sel);
        case (sel)
            2'd0:    pri_mask = PRI_MASK_2L;
            2'd1:    pri_mask = PRI_MASK_4L;
            default: pri_mask = PRI_MASK_8L;
        endcase
    endfunction

endpackage

// File: rtl/wb_dma_rr_pick.sv
// Combinational winner search: highest masked priority among requesters,
// ties resolved by the first requester at or above rr_ptr, wrapping around.
module wb_dma_rr_pick
    import wb_dma_sched_pkg::*;
#(
    parameter int CH_NUM = CH_NUM_DEF,
    parameter int PRI_W  = PRI_W_DEF
) (
    input  logic [CH_NUM-1:0]       req_i,
    input  logic [CH_NUM*PRI_W-1:0] pri_i,
    input  logic [1:0]              pri_sel_i,
    input  logic [4:0]              rr_ptr_i,
    output logic                    found_o,
    output logic [4:0]              win_ch_o,
    output logic [PRI_W-1:0]        win_pri_o
);

    logic [7:0]       mask;
    logic [PRI_W-1:0] eff_pri [CH_NUM];
    logic [PRI_W-1:0] max_pri;
    logic [5:0]       idx;

    assign mask = pri_mask(pri_sel_i);

    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_eff
            assign eff_pri[gi] = pri_i[PRI_W*gi +: PRI_W] & mask[PRI_W-1:0];
        end
    endgenerate

    always_comb begin
        max_pri   = '0;
        found_o   = 1'b0;
        win_ch_o  = '0;
        win_pri_o = '0;
        idx       = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (req_i[i] && (eff_pri[i] > max_pri)) begin
                max_pri = eff_pri[i];
            end
        end
        // rr_ptr is always < CH_NUM, so a single subtraction suffices to wrap.
        for (int k = 0; k < CH_NUM; k++) begin
            idx = {1'b0, rr_ptr_i} + 6'(k);
            if (idx >= 6'(CH_NUM)) begin
                idx = idx - 6'(CH_NUM);
            end
            if (!found_o && req_i[idx[4:0]] && (eff_pri[idx[4:0]] == max_pri)) begin
                found_o   = 1'b1;
                win_ch_o  = idx[4:0];
                win_pri_o = max_pri;
            end
        end
    end

endmodule

// File: rtl/wb_dma_ch_sched.sv
// DMA channel scheduler: arbitrates requesting channels, offers one grant to
// the engine and holds it until the engine reports completion.
module wb_dma_ch_sched
    import wb_dma_sched_pkg::*;
#(
    parameter int CH_NUM = CH_NUM_DEF,
    parameter int PRI_W  = PRI_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CH_NUM-1:0]       ch_req,
    input  logic [CH_NUM*PRI_W-1:0] ch_pri,
    input  logic [1:0]              pri_sel,
    input  logic                    de_ack,
    input  logic                    de_done,
    output logic                    gnt_valid,
    output logic [4:0]              gnt_ch,
    output logic [PRI_W-1:0]        gnt_pri,
    output logic                    busy
);

    sched_state_e     state_q, state_d;
    logic [4:0]       rr_ptr_q, rr_ptr_d;
    logic [4:0]       gnt_ch_q, gnt_ch_d;
    logic [PRI_W-1:0] gnt_pri_q, gnt_pri_d;

    logic             pick_found;
    logic [4:0]       pick_ch;
    logic [PRI_W-1:0] pick_pri;

    wb_dma_rr_pick #(
        .CH_NUM (CH_NUM),
        .PRI_W  (PRI_W)
    ) u_pick (
        .req_i     (ch_req),
        .pri_i     (ch_pri),
        .pri_sel_i (pri_sel),
        .rr_ptr_i  (rr_ptr_q),
        .found_o   (pick_found),
        .win_ch_o  (pick_ch),
        .win_pri_o (pick_pri)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            gnt_ch_q  <= '0;
            gnt_pri_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_ch_q  <= gnt_ch_d;
            gnt_pri_q <= gnt_pri_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_ch_d  = gnt_ch_q;
        gnt_pri_d = gnt_pri_q;
        case (state_q)
            ST_IDLE: begin
                if (|ch_req) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (pick_found) begin
                    state_d   = ST_GRANT;
                    gnt_ch_d  = pick_ch;
                    gnt_pri_d = pick_pri;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // Acceptance takes precedence over a simultaneous withdrawal.
                if (de_ack) begin
                    state_d = ST_BUSY;
                end else if (!ch_req[gnt_ch_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (de_done) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (gnt_ch_q == 5'(CH_NUM - 1)) ? 5'd0 : gnt_ch_q + 5'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign gnt_valid = (state_q == ST_GRANT);
    assign busy      = (state_q == ST_BUSY);
    assign gnt_ch    = gnt_ch_q;
    assign gnt_pri   = gnt_pri_q;

endmodule

// File: tb/tb_wb_dma_ch_sched.sv
// Directed bench for wb_dma_ch_sched with hand-computed expected grants.
module tb_wb_dma_ch_sched;

    localparam int CH_NUM = 31;
    localparam int PRI_W  = 3;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [CH_NUM-1:0]       ch_req;
    logic [CH_NUM*PRI_W-1:0] ch_pri;
    logic [1:0]              pri_sel;
    logic                    de_ack;
    logic                    de_done;
    logic                    gnt_valid;
    logic [4:0]              gnt_ch;
    logic [PRI_W-1:0]        gnt_pri;
    logic                    busy;

    int n_tests = 0;
    int n_fail  = 0;

    wb_dma_ch_sched #(
        .CH_NUM (CH_NUM),
        .PRI_W  (PRI_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_req    (ch_req),
        .ch_pri    (ch_pri),
        .pri_sel   (pri_sel),
        .de_ack    (de_ack),
        .de_done   (de_done),
        .gnt_valid (gnt_valid),
        .gnt_ch    (gnt_ch),
        .gnt_pri   (gnt_pri),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pri(input int ch, input logic [PRI_W-1:0] p);
        ch_pri[PRI_W*ch +: PRI_W] = p;
    endtask

    task automatic do_reset();
        ch_req  = '0;
        ch_pri  = '0;
        de_ack  = 1'b0;
        de_done = 1'b0;
        rst_n   = 1'b0;
        #3;
        rst_n   = 1'b1;
        tick();
    endtask

    // From GRANT: accept, then finish one cycle later; ends back in IDLE.
    task automatic ack_done();
        de_ack = 1'b1;
        tick();
        de_ack  = 1'b0;
        de_done = 1'b1;
        tick();
        de_done = 1'b0;
    endtask

    initial begin
        ch_req  = '0;
        ch_pri  = '0;
        pri_sel = 2'd2;
        de_ack  = 1'b0;
        de_done = 1'b0;
        rst_n   = 1'b0;
        #2;
        check("rst_gnt_valid", 32'(gnt_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_gnt_ch",    32'(gnt_ch),    32'd0);
        check("rst_gnt_pri",   32'(gnt_pri),   32'd0);
        rst_n = 1'b1;
        tick();

        // Highest priority wins; grant appears two edges after the request.
        set_pri(3, 3'd5);
        set_pri(7, 3'd2);
        ch_req[3] = 1'b1;
        ch_req[7] = 1'b1;
        de_ack = 1'b1;                       // ignored outside GRANT
        tick();
        de_ack = 1'b0;
        check("pri_arb_gnt_valid", 32'(gnt_valid), 32'd0);
        check("pri_arb_busy",      32'(busy),      32'd0);
        tick();
        check("pri_gnt_valid", 32'(gnt_valid), 32'd1);
        check("pri_gnt_ch",    32'(gnt_ch),    32'd3);
        check("pri_gnt_pri",   32'(gnt_pri),   32'd5);
        de_done = 1'b1;                      // ignored outside BUSY
        tick();
        de_done = 1'b0;
        check("done_in_grant_ignored", 32'(gnt_valid), 32'd1);
        de_ack = 1'b1;
        tick();
        de_ack = 1'b0;
        check("ack_busy",       32'(busy),      32'd1);
        check("ack_gnt_valid",  32'(gnt_valid), 32'd0);
        ch_req[3] = 1'b0;
        ch_pri    = '0;
        set_pri(7, 3'd7);                    // no preemption while BUSY
        tick();
        check("busy_hold_ch", 32'(gnt_ch), 32'd3);
        check("busy_hold",    32'(busy),   32'd1);
        de_done = 1'b1;
        ch_req  = '0;
        tick();
        de_done = 1'b0;
        check("done_idle_busy", 32'(busy), 32'd0);

        // Round robin among equal priorities.
        do_reset();
        pri_sel = 2'd2;
        set_pri(2, 3'd4);
        set_pri(5, 3'd4);
        set_pri(9, 3'd4);
        ch_req[2] = 1'b1;
        ch_req[5] = 1'b1;
        ch_req[9] = 1'b1;
        begin
            int exp_seq [4] = '{2, 5, 9, 2};
            for (int n = 0; n < 4; n++) begin
                tick();
                tick();
                check($sformatf("rr_grant%0d_valid", n), 32'(gnt_valid), 32'd1);
                check($sformatf("rr_grant%0d_ch", n),    32'(gnt_ch),    32'(exp_seq[n]));
                ack_done();
            end
        end
        ch_req = '0;

        // Priority masking by pri_sel.
        do_reset();
        pri_sel = 2'd0;
        set_pri(1, 3'd6);
        set_pri(4, 3'd3);
        ch_req[1] = 1'b1;
        ch_req[4] = 1'b1;
        tick();
        tick();
        check("mask2_ch",  32'(gnt_ch),  32'd4);
        check("mask2_pri", 32'(gnt_pri), 32'd1);
        ack_done();
        do_reset();
        pri_sel = 2'd1;
        set_pri(1, 3'd2);
        set_pri(4, 3'd7);
        ch_req[1] = 1'b1;
        ch_req[4] = 1'b1;
        tick();
        tick();
        check("mask4_ch",  32'(gnt_ch),  32'd4);
        check("mask4_pri", 32'(gnt_pri), 32'd3);
        ack_done();

        // Withdrawal in GRANT; rr_ptr must not move.
        do_reset();
        pri_sel = 2'd2;
        set_pri(6, 3'd1);
        set_pri(8, 3'd1);
        ch_req[6] = 1'b1;
        ch_req[8] = 1'b1;
        tick();
        tick();
        check("wd_first_ch", 32'(gnt_ch), 32'd6);
        ch_req[6] = 1'b0;
        tick();
        check("wd_gnt_valid", 32'(gnt_valid), 32'd0);
        check("wd_busy",      32'(busy),      32'd0);
        ch_req[6] = 1'b1;
        tick();
        tick();
        check("wd_rr_kept_ch", 32'(gnt_ch), 32'd6);
        ch_req[6] = 1'b0;
        de_ack    = 1'b1;
        tick();
        de_ack = 1'b0;
        check("wd_ack_wins_busy", 32'(busy), 32'd1);
        de_done = 1'b1;
        tick();
        de_done = 1'b0;
        tick();
        tick();
        check("wd_after_done_ch", 32'(gnt_ch), 32'd8);
        ch_req = '0;
        ack_done();

        // Pointer wrap after servicing the last channel.
        do_reset();
        set_pri(0, 3'd2);
        set_pri(30, 3'd2);
        ch_req[30] = 1'b1;
        tick();
        tick();
        check("wrap_first_ch", 32'(gnt_ch), 32'd30);
        ch_req[0] = 1'b1;
        ack_done();
        tick();
        tick();
        check("wrap_next_ch", 32'(gnt_ch), 32'd0);
        ack_done();
        ch_req = '0;

        // Asynchronous reset while BUSY, then re-arbitration.
        do_reset();
        set_pri(12, 3'd3);
        ch_req[12] = 1'b1;
        tick();
        tick();
        de_ack = 1'b1;
        tick();
        de_ack = 1'b0;
        check("ar_busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_busy",      32'(busy),      32'd0);
        check("ar_gnt_valid", 32'(gnt_valid), 32'd0);
        check("ar_gnt_ch",    32'(gnt_ch),    32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        check("ar_rearb_not_yet", 32'(gnt_valid), 32'd0);
        tick();
        check("ar_regrant_valid", 32'(gnt_valid), 32'd1);
        check("ar_regrant_ch",    32'(gnt_ch),    32'd12);
        ch_req = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_dma_ch_sched.md
WB_DMA_CH_SCHED -- requirements
Module: wb_dma_ch_sched

Interface
REQ-001 SHALL have parameter CH_NUM, default 31, the number of channels (1..31).
REQ-002 SHALL have parameter PRI_W, default 3, the per-channel priority width.
REQ-003 SHALL have one clock and an asynchronous active-low reset; all state is on clk rising edge.
REQ-004 clk  input  1  system clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 ch_req  input  CH_NUM  per-channel request (channel valid AND enabled).
REQ-007 ch_pri  input  CH_NUM*PRI_W  packed priorities, channel i at [PRI_W*i+PRI_W-1 : PRI_W*i].
REQ-008 pri_sel  input  2  priority levels: 0 = 2 levels, 1 = 4 levels, 2/3 = 8 levels.
REQ-009 de_ack  input  1  engine accepts the current grant.
REQ-010 de_done  input  1  engine finished the granted channel.
REQ-011 gnt_valid  output  1  grant offered to engine.
REQ-012 gnt_ch  output  5  granted channel index.
REQ-013 gnt_pri  output  PRI_W  effective priority of granted channel.
REQ-014 busy  output  1  a channel is being serviced.

Function
REQ-015 States SHALL be IDLE, ARB, GRANT, BUSY.
REQ-016 Effective priority SHALL be ch_pri masked: pri_sel 0 keeps bit 0, 1 keeps bits [1:0], 2/3 keeps all bits.
REQ-017 IDLE: any ch_req bit set at an edge -> ARB; otherwise stay.
REQ-018 ARB: winner SHALL be the requesting channel with highest effective priority; ties go to the first requester at index >= rr_ptr, searching upward and wrapping CH_NUM-1 -> 0.
REQ-019 ARB: winner SHALL be registered into gnt_ch/gnt_pri -> GRANT; if no request remains -> IDLE with outputs unchanged.
REQ-020 gnt_valid SHALL be 1 exactly while in GRANT, so it rises two edges after a request is first sampled in IDLE.
REQ-021 GRANT: de_ack=1 -> BUSY; else if ch_req[gnt_ch]=0 (withdrawn) -> IDLE; de_ack beats withdrawal in the same cycle.
REQ-022 busy SHALL be 1 exactly while in BUSY; gnt_ch/gnt_pri SHALL hold stable in GRANT and BUSY.
REQ-023 BUSY: de_done=1 -> IDLE and rr_ptr <= gnt_ch+1, with gnt_ch=CH_NUM-1 wrapping to 0; no preemption by higher-priority requests.
REQ-024 de_ack outside GRANT and de_done outside BUSY SHALL be ignored.
REQ-025 A withdrawn grant SHALL NOT update rr_ptr.
REQ-026 Channels >= CH_NUM SHALL never be granted.

Reset
REQ-027 Reset SHALL force state IDLE, rr_ptr 0, gnt_valid 0, busy 0, gnt_ch 0, gnt_pri 0, immediately and asynchronously.
REQ-028 Reset asserted in GRANT or BUSY SHALL abandon the grant; after release the block re-arbitrates from IDLE.

Structure
REQ-029 Package wb_dma_sched_pkg SHALL hold the state enum, CH_NUM/PRI_W defaults, and the pri_sel mask constants.
REQ-030 Sub-module wb_dma_rr_pick SHALL contain the combinational masked-priority plus round-robin winner search used in ARB.

Verification
REQ-031 Request ch3 (pri 5) and ch7 (pri 2), pri_sel=2 -> gnt_valid two edges later, gnt_ch=3, gnt_pri=5.
REQ-032 Requests ch2, ch5, ch9 at equal priority 4, each ack+done, requests held -> grants in order 2, 5, 9, 2.
REQ-033 pri_sel=0 with ch1 pri 6 and ch4 pri 3 -> effective priorities 0 and 1, gnt_ch=4, gnt_pri=1.
REQ-034 Drop ch_req[gnt_ch] in GRANT without de_ack -> IDLE next edge, gnt_valid 0, rr_ptr unchanged; same cycle with de_ack=1 -> BUSY.
REQ-035 Grant ch30 with CH_NUM=31, done; then ch0 and ch30 equal priority -> rr_ptr=0, gnt_ch=0.
REQ-036 Assert rst_n=0 in BUSY -> busy, gnt_valid and gnt_ch go to 0 without a clock edge; after release a pending request is granted in two edges.
